// File: rtl/traffic_pkg.sv
// Phase encoding and lamp decode/transition helpers shared by the
// traffic-light monitor and its sub-blocks.
package traffic_pkg;

    typedef enum logic [2:0] {
        PH_OFF        = 3'd0,
        PH_RED        = 3'd1,
        PH_RED_YELLOW = 3'd2,
        PH_GREEN      = 3'd3,
        PH_YELLOW     = 3'd4,
        PH_INVALID    = 3'd7
    } phase_e;

    function automatic phase_e decode_lamps(input logic r, input logic y, input logic g);
        phase_e ph;
        case ({r, y, g})
            3'b000:  ph = PH_OFF;
            3'b100:  ph = PH_RED;
            3'b110:  ph = PH_RED_YELLOW;
            3'b001:  ph = PH_GREEN;
            3'b010:  ph = PH_YELLOW;
            default: ph = PH_INVALID;
        endcase
        return ph;
    endfunction

    function automatic logic legal_trans(input phase_e from_ph, input phase_e to_ph,
                                         input logic allow_force_red);
        logic ok;
        ok = 1'b0;
        if (to_ph == PH_INVALID) begin
            ok = 1'b0;
        end else if (from_ph == PH_OFF) begin
            ok = 1'b1;
        end else if (allow_force_red && (to_ph == PH_RED)) begin
            ok = 1'b1;
        end else begin
            case (from_ph)
                PH_RED:        ok = (to_ph == PH_RED_YELLOW);
                PH_RED_YELLOW: ok = (to_ph == PH_GREEN);
                PH_GREEN:      ok = (to_ph == PH_YELLOW);
                PH_YELLOW:     ok = (to_ph == PH_RED);
                default:       ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Lamp lines and status/error outputs between the lamp driver (master)
// and the monitor (slave).
interface traffic_light_monitor_if #(
    parameter int DW = 8
);
    logic          red;
    logic          yellow;
    logic          green;
    logic          clr_err;
    logic [2:0]    phase;
    logic          phase_chg;
    logic [DW-1:0] last_dwell;
    logic          timeout;
    logic          illegal_combo;
    logic          illegal_trans;
    logic [7:0]    err_count;

    modport master (
        output red, yellow, green, clr_err,
        input  phase, phase_chg, last_dwell, timeout,
        input  illegal_combo, illegal_trans, err_count
    );

    modport slave (
        input  red, yellow, green, clr_err,
        output phase, phase_chg, last_dwell, timeout,
        output illegal_combo, illegal_trans, err_count
    );
endinterface

// File: rtl/traffic_light_monitor_dwell_counter.sv
// Phase dwell counter: restarts at 1 on a phase change, capturing the
// outgoing count; otherwise counts up and saturates.
module tl_dwell_counter #(
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_chg,
    output logic [DW-1:0] o_dwell,
    output logic [DW-1:0] o_last
);
    localparam logic [DW-1:0] LP_SAT = {DW{1'b1}};
    localparam logic [DW-1:0] LP_ONE = {{(DW-1){1'b0}}, 1'b1};

    logic [DW-1:0] r_dwell;
    logic [DW-1:0] r_last;

    // Dwell count and last-dwell capture
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dwell <= {DW{1'b0}};
            r_last  <= {DW{1'b0}};
        end else if (i_chg) begin
            r_last  <= r_dwell;
            r_dwell <= LP_ONE;
        end else if (r_dwell != LP_SAT) begin
            r_dwell <= r_dwell + LP_ONE;
        end else begin
            r_dwell <= r_dwell;
        end
    end

    assign o_dwell = r_dwell;
    assign o_last  = r_last;
endmodule

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for controller lamp lines: decodes the phase,
// times each phase and flags illegal lamp combinations and transitions.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int DW              = 8,
    parameter int MAX_DWELL       = 16,
    parameter int ALLOW_FORCE_RED = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    traffic_light_monitor_if.slave  bus
);
    localparam logic [DW-1:0] LP_MAX_DWELL = DW'(MAX_DWELL);
    localparam logic          LP_FORCE_RED = (ALLOW_FORCE_RED != 0);

    phase_e        r_phase;
    logic          r_phase_chg;
    logic          r_illegal_combo;
    logic          r_illegal_trans;
    logic [7:0]    r_err_count;

    phase_e        w_dec;
    logic          w_chg;
    logic          w_combo_evt;
    logic          w_trans_evt;
    logic          w_evt;
    logic [DW-1:0] w_dwell;
    logic [DW-1:0] w_last;

    assign w_dec = decode_lamps(bus.red, bus.yellow, bus.green);
    assign w_chg = (w_dec != r_phase);
    assign w_evt = w_combo_evt | w_trans_evt;

    // Classify a phase change; leaving INVALID is never a transition error
    always_comb begin
        w_combo_evt = 1'b0;
        w_trans_evt = 1'b0;
        if (!w_chg) begin
            w_combo_evt = 1'b0;
        end else if (w_dec == PH_INVALID) begin
            w_combo_evt = 1'b1;
        end else if (r_phase == PH_INVALID) begin
            w_trans_evt = 1'b0;
        end else begin
            w_trans_evt = !legal_trans(r_phase, w_dec, LP_FORCE_RED);
        end
    end

    // Phase register, change pulse, sticky flags and saturating error count
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_phase         <= PH_OFF;
            r_phase_chg     <= 1'b0;
            r_illegal_combo <= 1'b0;
            r_illegal_trans <= 1'b0;
            r_err_count     <= 8'd0;
        end else begin
            r_phase     <= w_dec;
            r_phase_chg <= w_chg;
            if (bus.clr_err) begin
                r_illegal_combo <= w_combo_evt;
                r_illegal_trans <= w_trans_evt;
                r_err_count     <= w_evt ? 8'd1 : 8'd0;
            end else begin
                r_illegal_combo <= r_illegal_combo | w_combo_evt;
                r_illegal_trans <= r_illegal_trans | w_trans_evt;
                if (w_evt && (r_err_count != 8'hFF)) begin
                    r_err_count <= r_err_count + 8'd1;
                end else begin
                    r_err_count <= r_err_count;
                end
            end
        end
    end

    tl_dwell_counter #(.DW(DW)) u_dwell (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_chg   (w_chg),
        .o_dwell (w_dwell),
        .o_last  (w_last)
    );

    assign bus.phase         = r_phase;
    assign bus.phase_chg     = r_phase_chg;
    assign bus.last_dwell    = w_last;
    assign bus.timeout       = (w_dwell >= LP_MAX_DWELL);
    assign bus.illegal_combo = r_illegal_combo;
    assign bus.illegal_trans = r_illegal_trans;
    assign bus.err_count     = r_err_count;
endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
Receive-side checker for the red/yellow/green lamp signals driven by the traffic-light controller.
- Samples the three lamp lines every clock and decodes them into a phase.
- Checks the phase sequence against the legal order RED -> RED_YELLOW -> GREEN -> YELLOW -> RED.
- Measures how long each phase lasts and flags lamp combinations and transitions that are not allowed.
- Sits beside the controller in the top-level testbench and feeds status/error outputs to the waveform dump and display.

Parameters:
DW, 8, width of the dwell counter and of last_dwell (cycles).
MAX_DWELL, 16, dwell count at and above which timeout is asserted; must be < 2^DW.
ALLOW_FORCE_RED, 1, if 1, a transition from any phase to RED is legal (pedestrian-button override).

Ports:
clk  input  1  system clock, all state on rising edge.
rst  input  1  synchronous, active-high reset.
red  input  1  red lamp line from the controller.
yellow  input  1  yellow lamp line.
green  input  1  green lamp line.
clr_err  input  1  clears sticky error flags and err_count.
phase  output  3  decoded current phase (encoding in package).
phase_chg  output  1  one-cycle pulse when phase changes.
last_dwell  output  DW  duration in cycles of the phase just left.
timeout  output  1  current phase dwell >= MAX_DWELL.
illegal_combo  output  1  sticky: an INVALID lamp combination was seen.
illegal_trans  output  1  sticky: an illegal phase transition was seen.
err_count  output  8  saturating count of error events.

Behaviour:
- Reset (rst=1 at an edge): all outputs go to 0; phase=OFF; dwell=0. Reset mid-sequence discards history, so the next transition is from OFF.
- Decode of {r,y,g}:
  - 000 = OFF
  - 100 = RED
  - 110 = RED_YELLOW
  - 001 = GREEN
  - 010 = YELLOW
  - any other pattern (green with red or yellow) = INVALID
- Latency: phase register loads the decode of the lamp inputs at each edge, so phase lags the lamps by 1 cycle.
- Change detection: a change means decode != phase.
  - On a change: phase_chg=1 for exactly 1 cycle, last_dwell <= dwell, dwell <= 1.
  - Otherwise dwell increments and saturates at 2^DW-1. last_dwell holds.
- Legal transitions:
  - RED->RED_YELLOW, RED_YELLOW->GREEN, GREEN->YELLOW, YELLOW->RED.
  - OFF->any non-INVALID phase.
  - any->RED when ALLOW_FORCE_RED=1.
- Error events:
  - Entry into INVALID sets illegal_combo (INVALID->x raises no transition error).
  - Any other change not in the legal list sets illegal_trans. This includes any->OFF (lamp failure).
  - A change back to the same phase cannot occur and is not an event.
  - Each event increments err_count by 1, saturating at 255.
- clr_err:
  - Clears illegal_combo, illegal_trans and err_count at the edge.
  - If an error event occurs in the same cycle, the event wins: flag=1, err_count=1.
- timeout: combinational compare dwell >= MAX_DWELL, on the registered dwell. Drops in the cycle after a phase change.
- Not affected by clr_err: phase, phase_chg, dwell, last_dwell, timeout.

Decomposition:
- Package traffic_pkg holds:
  - phase encoding constants: OFF=0, RED=1, RED_YELLOW=2, GREEN=3, YELLOW=4, INVALID=7;
  - a decode function for {r,y,g};
  - a legal-transition function taking (from, to, allow_force_red).
- One sub-module tl_dwell_counter (parameter DW): load-1/increment/saturate counter with last-value capture on change.
- Top module holds the phase register, error logic and err_count.

Test Plan:
- Controller 8-step cycle (RY, G, G, Y, Y, R, R, R, repeat) after reset: phase steps OFF->RED_YELLOW->GREEN->YELLOW->RED; last_dwell values 1, 2, 2, 3; illegal_trans=0, illegal_combo=0, err_count=0.
- Drive GREEN directly from RED with ALLOW_FORCE_RED=1: illegal_trans=1, err_count=1. Then GREEN->RED is accepted with no further error.
- Drive {1,0,1} for 1 cycle: phase=7, illegal_combo=1, err_count increments by 1. Returning to RED adds no transition error.
- Hold RED for 20 cycles with MAX_DWELL=16: timeout rises on the 16th cycle of dwell and stays 1. A change to RED_YELLOW gives phase_chg=1, last_dwell=20, and timeout=0 on the next cycle.
- clr_err asserted together with an illegal transition: after the edge illegal_trans=1, err_count=1. clr_err alone on the next cycle: both 0.
- rst asserted mid-GREEN for 1 cycle: phase=0, dwell=0, all flags 0. The next GREEN sample is an OFF->GREEN transition with no error.
